// File: rtl/conv1d_operand_feeder_pkg.sv
// Shared constants and state encoding for the conv1d operand feeder and its MAC partner.
package conv1d_operand_feeder_pkg;

    localparam int FRAC_BITS = 6;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Counter value the ALU treats as "no tap": all ones, never 0 or K-1.
    function automatic int idle_code(input int cnt_width);
        return (1 << cnt_width) - 1;
    endfunction

endpackage

// File: rtl/conv1d_operand_feeder_window.sv
// K-deep sample shift register; taps[0] is the oldest sample, new samples enter at taps[K-1].
module sample_window_shifter #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clear,
    input  logic                                   load,
    input  logic [DATA_WIDTH-1:0]                  din,
    output logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] taps
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else if (clear) begin
            taps <= '0;
        end else if (load) begin
            for (int i = 0; i < KERNEL_SIZE - 1; i++) taps[i] <= taps[i+1];
            taps[KERNEL_SIZE-1] <= din;
        end
    end

endmodule

// File: rtl/conv1d_operand_feeder.sv
// Streams one (weight, activation, tap index) triple per clock for each sliding window of samples.
module conv1d_operand_feeder
    import conv1d_operand_feeder_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int KERNEL_SIZE   = 5,
    parameter int CNT_WIDTH     = 3,
    parameter int WIN_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_in,
    input  logic [DATA_WIDTH-1:0]    s_data_in,
    input  logic                     s_valid_in,
    output logic                     s_ready_out,
    input  logic                     w_we_in,
    input  logic [CNT_WIDTH-1:0]     w_addr_in,
    input  logic [DATA_WIDTH-1:0]    w_data_in,
    output logic                     w_busy_out,
    output logic [DATA_WIDTH-1:0]    Filter_out,
    output logic [DATA_WIDTH-1:0]    IA_out,
    output logic [CNT_WIDTH-1:0]     CTRL_counter_out,
    output logic                     op_valid_out,
    output logic [WIN_CNT_WIDTH-1:0] win_count_out
);

    localparam logic [CNT_WIDTH-1:0] IDLE = CNT_WIDTH'(idle_code(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] KSZ  = CNT_WIDTH'(KERNEL_SIZE);

    state_t                                 state;
    logic [CNT_WIDTH-1:0]                   cnt;
    logic [CNT_WIDTH-1:0]                   fill_cnt;
    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] weights;
    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] taps;
    logic                                   accept;

    // Ready reopens on the last tap so the next window can start without a bubble.
    assign s_ready_out = (state != EMIT) || (cnt == LAST);
    assign w_busy_out  = (state == EMIT);
    assign accept      = s_valid_in && s_ready_out && !clear_in;

    sample_window_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .KERNEL_SIZE(KERNEL_SIZE)
    ) u_window (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear_in),
        .load (accept),
        .din  (s_data_in),
        .taps (taps)
    );

    // Weights survive clear_in; only reset wipes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weights <= '0;
        end else if (w_we_in && !w_busy_out && !clear_in && (w_addr_in < KSZ)) begin
            weights[w_addr_in] <= w_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= FILL;
            cnt              <= '0;
            fill_cnt         <= '0;
            Filter_out       <= '0;
            IA_out           <= '0;
            CTRL_counter_out <= IDLE;
            op_valid_out     <= 1'b0;
            win_count_out    <= '0;
        end else if (clear_in) begin
            state            <= FILL;
            cnt              <= '0;
            fill_cnt         <= '0;
            Filter_out       <= '0;
            IA_out           <= '0;
            CTRL_counter_out <= IDLE;
            op_valid_out     <= 1'b0;
            win_count_out    <= '0;
        end else begin
            Filter_out       <= '0;
            IA_out           <= '0;
            CTRL_counter_out <= IDLE;
            op_valid_out     <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        if (fill_cnt == LAST) begin
                            state    <= EMIT;
                            cnt      <= '0;
                            fill_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // Taps read the pre-shift window even when a new sample lands this edge.
                    Filter_out       <= weights[cnt];
                    IA_out           <= taps[cnt];
                    CTRL_counter_out <= cnt;
                    op_valid_out     <= 1'b1;
                    if (cnt == LAST) begin
                        win_count_out <= win_count_out + 1'b1;
                        if (accept) cnt <= '0;
                        else        state <= WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (accept) begin
                        state <= EMIT;
                        cnt   <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1d_operand_feeder.sv
// Directed plus random bench for conv1d_operand_feeder against a tap-queue reference model.
module tb_conv1d_operand_feeder;

    localparam int DW = 16, K = 5, CW = 3, WW = 16;

    logic          clk = 1'b0, rst_n = 1'b0, clear_in = 1'b0;
    logic          s_valid_in = 1'b0, w_we_in = 1'b0;
    logic [DW-1:0] s_data_in = '0, w_data_in = '0;
    logic [CW-1:0] w_addr_in = '0;
    logic          s_ready_out, w_busy_out, op_valid_out;
    logic [DW-1:0] Filter_out, IA_out;
    logic [CW-1:0] CTRL_counter_out;
    logic [WW-1:0] win_count_out;

    conv1d_operand_feeder #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(K), .CNT_WIDTH(CW), .WIN_CNT_WIDTH(WW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear_in(clear_in),
        .s_data_in(s_data_in), .s_valid_in(s_valid_in), .s_ready_out(s_ready_out),
        .w_we_in(w_we_in), .w_addr_in(w_addr_in), .w_data_in(w_data_in), .w_busy_out(w_busy_out),
        .Filter_out(Filter_out), .IA_out(IA_out), .CTRL_counter_out(CTRL_counter_out),
        .op_valid_out(op_valid_out), .win_count_out(win_count_out)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a queue of taps still to be presented; a window of K taps is queued
    // whenever an accepted sample completes K samples since the last flush.
    typedef struct { int f; int a; int c; int v; } tap_t;
    tap_t q[$];
    int   hist[$];
    int   mw[K];
    int   winc = 0;
    tap_t mo = '{0, 0, 7, 0};
    bit   chk_en = 0;
    bit   m_acc;
    int   m_wa;

    always @(negedge rst_n) begin
        q.delete();
        hist.delete();
        foreach (mw[i]) mw[i] = 0;
        winc = 0;
        mo = '{0, 0, 7, 0};
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (clear_in) begin
                q.delete();
                hist.delete();
                winc = 0;
                mo = '{0, 0, 7, 0};
            end else begin
                m_acc = s_valid_in && (q.size() <= 1);
                m_wa  = int'(w_addr_in);
                if (w_we_in && q.size() == 0 && m_wa < K) mw[m_wa] = int'($signed(w_data_in));
                if (q.size() > 0) begin
                    mo = q.pop_front();
                    if (mo.c == K - 1) winc++;
                end else begin
                    mo = '{0, 0, 7, 0};
                end
                if (m_acc) begin
                    hist.push_back(int'($signed(s_data_in)));
                    if (hist.size() > K) void'(hist.pop_front());
                    if (hist.size() == K)
                        for (int i = 0; i < K; i++) q.push_back('{mw[i], hist[i], i, 1});
                end
            end
        end
        #1;
        if (chk_en) begin
            chk("filter", int'($signed(Filter_out)), mo.f);
            chk("ia", int'($signed(IA_out)), mo.a);
            chk("ctrl", int'(CTRL_counter_out), mo.c);
            chk("op_valid", int'(op_valid_out), mo.v);
            chk("win_count", int'(win_count_out), winc & 16'hFFFF);
            chk("s_ready", int'(s_ready_out), (q.size() <= 1) ? 1 : 0);
            chk("w_busy", int'(w_busy_out), (q.size() > 0) ? 1 : 0);
        end
    end

    // All tasks are entered and left at a negedge.
    task automatic wr(input int a, input int d);
        w_we_in = 1'b1; w_addr_in = CW'(a); w_data_in = DW'(d);
        @(negedge clk);
        w_we_in = 1'b0;
    endtask

    task automatic push(input int v);
        int n = 0;
        s_data_in = DW'(v); s_valid_in = 1'b1;
        while (!s_ready_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL push_timeout actual=%0d required<50", n);
        end
        @(negedge clk);
    endtask

    task automatic clr();
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
    endtask

    int exp3[K] = '{-64, 32, 0, 127, -32768};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ctrl", int'(CTRL_counter_out), 7);
        chk("rst_filter", int'(Filter_out), 0);
        chk("rst_opv", int'(op_valid_out), 0);
        chk("rst_ready", int'(s_ready_out), 1);
        chk("rst_win", int'(win_count_out), 0);
        rst_n = 1'b1; chk_en = 1;

        // Unit weights, one window.
        for (int i = 0; i < K; i++) wr(i, 64);
        for (int v = 1; v <= 5; v++) push(v);
        s_valid_in = 1'b0;
        for (int k = 0; k < K; k++) begin
            @(negedge clk);
            chk("t1_filter", int'($signed(Filter_out)), 64);
            chk("t1_ia", int'($signed(IA_out)), k + 1);
            chk("t1_ctrl", int'(CTRL_counter_out), k);
        end
        @(negedge clk);
        chk("t1_idle_ctrl", int'(CTRL_counter_out), 7);
        chk("t1_idle_opv", int'(op_valid_out), 0);
        chk("t1_win", int'(win_count_out), 1);

        // Back-to-back windows.
        clr();
        for (int v = 1; v <= 8; v++) push(v);
        s_valid_in = 1'b0;
        repeat (6) @(negedge clk);
        chk("t2_win", int'(win_count_out), 4);
        chk("t2_idle", int'(CTRL_counter_out), 7);

        // Signed extremes, plus a weight write attempted mid-window.
        clr();
        for (int i = 0; i < K; i++) wr(i, exp3[i]);
        for (int v = 1; v <= 5; v++) push(-v);
        s_valid_in = 1'b0;
        for (int k = 0; k < K; k++) begin
            if (k == 0) begin
                chk("t4_busy", int'(w_busy_out), 1);
                w_we_in = 1'b1; w_addr_in = 3'd2; w_data_in = 16'd99;
            end
            @(negedge clk);
            w_we_in = 1'b0;
            chk("t3_filter", int'($signed(Filter_out)), exp3[k]);
            chk("t3_ia", int'($signed(IA_out)), -(k + 1));
        end
        @(negedge clk);
        wr(2, 99);
        wr(6, 555);
        push(-6);
        s_valid_in = 1'b0;
        for (int k = 0; k < K; k++) begin
            @(negedge clk);
            if (k == 2) begin
                chk("t4_filter2", int'($signed(Filter_out)), 99);
                chk("t4_ia2", int'($signed(IA_out)), -4);
            end
            if (k == 4) chk("t4_filter4", int'($signed(Filter_out)), -32768);
        end

        // Clear at tap 2 together with a sample.
        @(negedge clk);
        push(-7);
        s_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        clear_in = 1'b1; s_valid_in = 1'b1; s_data_in = 16'd100;
        @(negedge clk);
        clear_in = 1'b0; s_valid_in = 1'b0;
        chk("t5_ctrl", int'(CTRL_counter_out), 7);
        chk("t5_opv", int'(op_valid_out), 0);
        chk("t5_ready", int'(s_ready_out), 1);
        chk("t5_win", int'(win_count_out), 0);
        for (int v = 200; v < 204; v++) push(v);
        s_valid_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_tap", int'(op_valid_out), 0);
        end
        push(204);
        s_valid_in = 1'b0;
        @(negedge clk);
        chk("t5_first_ia", int'($signed(IA_out)), 200);
        chk("t5_first_ctrl", int'(CTRL_counter_out), 0);

        // Asynchronous reset mid-window.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_ctrl", int'(CTRL_counter_out), 7);
        chk("t6_filter", int'(Filter_out), 0);
        chk("t6_opv", int'(op_valid_out), 0);
        chk("t6_win", int'(win_count_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int v = 1; v <= 5; v++) push(v);
        s_valid_in = 1'b0;
        @(negedge clk);
        chk("t6_w0", int'($signed(Filter_out)), 0);
        chk("t6_ia0", int'($signed(IA_out)), 1);

        // Random traffic.
        repeat (1500) begin
            s_valid_in = ($urandom_range(0, 9) < 7);
            s_data_in  = DW'($urandom);
            w_we_in    = ($urandom_range(0, 4) == 0);
            w_addr_in  = CW'($urandom_range(0, 7));
            w_data_in  = DW'($urandom);
            clear_in   = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        s_valid_in = 1'b0; w_we_in = 1'b0; clear_in = 1'b0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
